// File: rtl/sm2_nonce_gen.sv
// rtl/sm2_nonce_gen.sv - SM2 nonce k generator: word-serial entropy collection with rejection sampling into [1, n-1]
// Optional macro SM2_NONCE_ZEROIZE_EN clears k_out after delivery and scrubs the candidate register on the way to ERR.
module sm2_nonce_gen #(
  parameter int ENT_W   = 32,
  parameter int MAX_REJ = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ent_valid,
  input  logic [ENT_W-1:0] ent_data,
  output logic             ent_ready,
  output logic [255:0]     k_out,
  output logic             k_valid,
  input  logic             k_ready,
  output logic             busy,
  output logic             err,
  output logic [7:0]       rej_cnt
);

  localparam int WORDS = 256 / ENT_W;
  localparam int WCW   = $clog2(WORDS + 1);
  localparam logic [255:0] N_ORDER =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_HOLD,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [255:0]     r_shreg;
  logic [WCW-1:0]   r_wcnt;
  logic [255:0]     r_k_out;
  logic             r_k_valid;
  logic             r_ent_ready;
  logic             r_busy;
  logic             r_err;
  logic [7:0]       r_rej_cnt;

  logic [255:0]     w_shift;
  logic             w_accept;
  logic             w_last_word;
  logic             w_in_range;
  logic [7:0]       w_rej_next;

  // First accepted word ends up in the most significant bits once all WORDS are shifted in.
  generate
    if (ENT_W == 256) begin : g_full_word
      assign w_shift = ent_data;
    end else begin : g_part_word
      assign w_shift = {r_shreg[255-ENT_W:0], ent_data};
    end
  endgenerate

  assign w_accept    = ent_valid && r_ent_ready;
  assign w_last_word = (r_wcnt == WCW'(WORDS - 1));
  assign w_in_range  = (r_shreg != 256'd0) && (r_shreg < N_ORDER);
  assign w_rej_next  = r_rej_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_wcnt      <= '0;
      r_k_out     <= '0;
      r_k_valid   <= 1'b0;
      r_ent_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_rej_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_COLLECT;
            r_rej_cnt   <= 8'd0;
            r_wcnt      <= '0;
            r_shreg     <= '0;
            r_ent_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        S_COLLECT: begin
          if (w_accept) begin
            r_shreg <= w_shift;
            r_wcnt  <= r_wcnt + WCW'(1);
            if (w_last_word) begin
              r_state     <= S_CHECK;
              r_ent_ready <= 1'b0;
            end
          end
        end

        S_CHECK: begin
          if (w_in_range) begin
            r_k_out   <= r_shreg;
            r_k_valid <= 1'b1;
            r_state   <= S_HOLD;
          end else begin
            // rej_cnt cannot wrap: reaching MAX_REJ parks the block in ERR.
            r_rej_cnt <= w_rej_next;
            if (w_rej_next == 8'(MAX_REJ)) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_ERR;
`ifdef SM2_NONCE_ZEROIZE_EN
              r_shreg <= '0;
`endif
            end else begin
              r_wcnt      <= '0;
              r_shreg     <= '0;
              r_ent_ready <= 1'b1;
              r_state     <= S_COLLECT;
            end
          end
        end

        S_HOLD: begin
          if (r_k_valid && k_ready) begin
            r_k_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
`ifdef SM2_NONCE_ZEROIZE_EN
            r_k_out   <= '0;
`endif
          end
        end

        S_ERR: begin
          if (start) begin
            r_err       <= 1'b0;
            r_rej_cnt   <= 8'd0;
            r_wcnt      <= '0;
            r_shreg     <= '0;
            r_ent_ready <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_COLLECT;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_ent_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_k_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign ent_ready = r_ent_ready;
  assign k_out     = r_k_out;
  assign k_valid   = r_k_valid;
  assign busy      = r_busy;
  assign err       = r_err;
  assign rej_cnt   = r_rej_cnt;

endmodule

// File: tb/tb_sm2_nonce_gen.sv
// tb/tb_sm2_nonce_gen.sv - directed self-checking bench for sm2_nonce_gen (ENT_W=32, MAX_REJ=15)
module tb_sm2_nonce_gen;

  localparam logic [255:0] N_ORDER =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123;
  localparam logic [255:0] N_M1 =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54122;
  localparam logic [255:0] K_SEQ =
    256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007;
  localparam logic [255:0] K_FRESH =
    256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         ent_valid;
  logic [31:0]  ent_data;
  logic         ent_ready;
  logic [255:0] k_out;
  logic         k_valid;
  logic         k_ready;
  logic         busy;
  logic         err;
  logic [7:0]   rej_cnt;

  int tests;
  int fails;
  logic seen_kv;

  sm2_nonce_gen #(.ENT_W(32), .MAX_REJ(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ent_valid (ent_valid),
    .ent_data  (ent_data),
    .ent_ready (ent_ready),
    .k_out     (k_out),
    .k_valid   (k_valid),
    .k_ready   (k_ready),
    .busy      (busy),
    .err       (err),
    .rej_cnt   (rej_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Feeds one 256-bit candidate as eight back-to-back words, most significant word first.
  task automatic send_cand(input logic [255:0] c);
    for (int i = 0; i < 8; i++) begin
      ent_valid = 1'b1;
      ent_data  = c[255 - 32*i -: 32];
      step();
    end
    ent_valid = 1'b0;
    ent_data  = 32'd0;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    seen_kv   = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    ent_valid = 1'b0;
    ent_data  = 32'd0;
    k_ready   = 1'b0;
    step();
    step();
    check("rst_k_valid", 256'(k_valid), 256'd0);
    check("rst_k_out", k_out, 256'd0);
    check("rst_ent_ready", 256'(ent_ready), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    rst_n = 1'b1;
    step();

    // 1: in-range candidate, 9-cycle latency, handshake
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_ent_ready_collect", 256'(ent_ready), 256'd1);
    check("t1_busy_collect", 256'(busy), 256'd1);
    send_cand(K_SEQ);
    check("t1_check_ent_ready", 256'(ent_ready), 256'd0);
    check("t1_kv_before_e9", 256'(k_valid), 256'd0);
    step();
    check("t1_kv_at_e9", 256'(k_valid), 256'd1);
    check("t1_k_out", k_out, K_SEQ);
    check("t1_rej_cnt", 256'(rej_cnt), 256'd0);
    k_ready = 1'b1;
    step();
    k_ready = 1'b0;
    check("t1_kv_after_hs", 256'(k_valid), 256'd0);
    check("t1_busy_after_hs", 256'(busy), 256'd0);
    check("t1_ent_ready_idle", 256'(ent_ready), 256'd0);
`ifdef SM2_NONCE_ZEROIZE_EN
    check("t6_k_out_zeroized", k_out, 256'd0);
`else
    check("t6_k_out_retained", k_out, K_SEQ);
`endif

    // 2: candidate == n rejected, n-1 accepted
    start = 1'b1;
    step();
    start = 1'b0;
    send_cand(N_ORDER);
    step();
    check("t2_rej_cnt", 256'(rej_cnt), 256'd1);
    check("t2_ent_ready_again", 256'(ent_ready), 256'd1);
    check("t2_kv_after_rej", 256'(k_valid), 256'd0);
    send_cand(N_M1);
    step();
    check("t2_kv_nm1", 256'(k_valid), 256'd1);
    check("t2_k_out_nm1", k_out, N_M1);
    k_ready = 1'b1;
    step();
    k_ready = 1'b0;

    // 3: fifteen zero candidates drive ERR
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < 15; r++) begin
      send_cand(256'd0);
      step();
      if (k_valid) seen_kv = 1'b1;
    end
    check("t3_err", 256'(err), 256'd1);
    check("t3_rej_cnt", 256'(rej_cnt), 256'd15);
    check("t3_busy", 256'(busy), 256'd0);
    check("t3_ent_ready", 256'(ent_ready), 256'd0);
    check("t3_kv_never", 256'(seen_kv), 256'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_err_cleared", 256'(err), 256'd0);
    check("t3_rej_cleared", 256'(rej_cnt), 256'd0);
    check("t3_ent_ready_restart", 256'(ent_ready), 256'd1);

    // 4: toggling ent_valid, all-FF candidate > n, start ignored while busy
    for (int i = 0; i < 16; i++) begin
      ent_valid = (i % 2 == 0);
      ent_data  = 32'hFFFF_FFFF;
      start     = (i == 3);
      step();
      start = 1'b0;
      if (i == 13) check("t4_still_collect", 256'(ent_ready), 256'd1);
      if (i == 14) check("t4_check_after_16", 256'(ent_ready), 256'd0);
    end
    ent_valid = 1'b0;
    check("t4_rej_cnt", 256'(rej_cnt), 256'd1);
    check("t4_ent_ready_back", 256'(ent_ready), 256'd1);
    send_cand(256'd1);
    step();
    check("t4_kv_one", 256'(k_valid), 256'd1);
    check("t4_k_out_one", k_out, 256'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_hold_start_kv", 256'(k_valid), 256'd1);
    check("t4_hold_start_busy", 256'(busy), 256'd1);
    start   = 1'b1;
    k_ready = 1'b1;
    step();
    start   = 1'b0;
    k_ready = 1'b0;
    check("t4_hs_start_kv", 256'(k_valid), 256'd0);
    check("t4_hs_start_busy", 256'(busy), 256'd0);
    check("t4_hs_start_ent_ready", 256'(ent_ready), 256'd0);

    // 5: asynchronous reset mid-collection, then clean restart
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ent_valid = 1'b1;
      ent_data  = 32'hAAAA_AAAA;
      step();
    end
    ent_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("t5_async_ent_ready", 256'(ent_ready), 256'd0);
    check("t5_async_busy", 256'(busy), 256'd0);
    check("t5_async_k_out", k_out, 256'd0);
    check("t5_async_rej_err", {248'd0, rej_cnt}, 256'd0);
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    send_cand(K_FRESH);
    step();
    check("t5_fresh_kv", 256'(k_valid), 256'd1);
    check("t5_fresh_k_out", k_out, K_FRESH);
    check("t5_fresh_rej", 256'(rej_cnt), 256'd0);
    k_ready = 1'b1;
    step();
    k_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
